// File: rtl/io_pins_fpga_ctrl.sv
// rtl/io_pins_fpga_ctrl.sv - pin bank controller: registered drive of a 17-byte image, or release and synchronized sampling
module io_pins_fpga_ctrl #(
    parameter int PINS_CONT = 132,
    localparam int NBYTES   = 17
) (
    input  logic                    CLK50,
    input  logic                    rst_n,
    input  logic                    write_enable,
    inout  wire  [PINS_CONT-1:0]    io_pins,
    input  logic [NBYTES-1:0][7:0]  memory_pin_state,
    output logic [NBYTES-1:0][7:0]  pin_sample
);

    localparam int IMG_BITS = 8 * NBYTES;

    logic                  oe_q;
    logic [PINS_CONT-1:0]  drv_q, drv_d;
    logic [PINS_CONT-1:0]  s1_q, s2_q;
    logic [PINS_CONT-1:0]  sample_q, sample_d;
    logic [IMG_BITS-1:0]   image_flat;
    logic [IMG_BITS-1:0]   sample_flat;

    assign image_flat = memory_pin_state;
    assign drv_d      = image_flat[PINS_CONT-1:0];

    // Image bits beyond the physical pin count have nowhere to go.
    generate
        if (PINS_CONT < IMG_BITS) begin : g_spare
            logic unused_image_bits;
            assign unused_image_bits = ^image_flat[IMG_BITS-1:PINS_CONT];
        end
    endgenerate

    // Frozen while driving so the bank never reports its own output levels.
    assign sample_d = oe_q ? sample_q : s2_q;

    always_ff @(posedge CLK50 or negedge rst_n) begin
        if (!rst_n) begin
            oe_q     <= 1'b0;
            drv_q    <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            sample_q <= '0;
        end else begin
            oe_q     <= write_enable;
            drv_q    <= drv_d;
            s1_q     <= io_pins;
            s2_q     <= s1_q;
            sample_q <= sample_d;
        end
    end

    assign io_pins = oe_q ? drv_q : {PINS_CONT{1'bz}};

    always_comb begin
        sample_flat                = '0;
        sample_flat[PINS_CONT-1:0] = sample_q;
    end

    assign pin_sample = sample_flat;

endmodule

// File: tb/tb_io_pins_fpga_ctrl.sv
// tb/tb_io_pins_fpga_ctrl.sv - directed bench for io_pins_fpga_ctrl drive, sample, freeze and reset behaviour
`timescale 1ns/1ps
module tb_io_pins_fpga_ctrl;

    localparam int PINS = 132;

    logic              CLK50 = 1'b0;
    logic              rst_n;
    logic              write_enable;
    logic [16:0][7:0]  img;
    logic [16:0][7:0]  pin_sample;
    tri0  [PINS-1:0]   io_pins;
    logic              tb_oe;
    logic [7:0]        tb_byte;

    int n_cmp  = 0;
    int n_fail = 0;

    io_pins_fpga_ctrl #(.PINS_CONT(PINS)) dut (
        .CLK50            (CLK50),
        .rst_n            (rst_n),
        .write_enable     (write_enable),
        .io_pins          (io_pins),
        .memory_pin_state (img),
        .pin_sample       (pin_sample)
    );

    assign io_pins[15:8] = tb_oe ? tb_byte : 8'hzz;

    always #10 CLK50 = ~CLK50;

    task automatic tick();
        @(posedge CLK50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [135:0] ones;
        ones = '0;
        ones[PINS-1:0] = '1;

        rst_n = 1'b0; write_enable = 1'b0; img = '0; tb_oe = 1'b0; tb_byte = 8'h00;
        tick(); tick();
        chk("reset_pins_z", 136'(io_pins), 136'h0);
        chk("reset_sample", 136'(pin_sample), 136'h0);

        // Drive: byte16 upper nibble has no pins behind it
        rst_n = 1'b1;
        write_enable = 1'b1; img[0] = 8'hA5; img[16] = 8'hFF;
        #1;
        chk("drive_before_edge", 136'(io_pins), 136'h0);
        tick();
        chk("drive_byte0", 136'(io_pins[7:0]), 136'hA5);
        chk("drive_byte16", 136'(io_pins[131:128]), 136'hF);
        chk("drive_middle", 136'(io_pins[127:8]), 136'h0);

        // Image update while driving
        img[3] = 8'hFF;
        #1;
        chk("img_before_edge", 136'(io_pins[31:24]), 136'h00);
        tick();
        chk("img_after_edge", 136'(io_pins[31:24]), 136'hFF);

        // Sample mode: release, then bench drives byte1
        write_enable = 1'b0;
        tick();
        chk("release_pins_z", 136'(io_pins), 136'h0);
        tb_oe = 1'b1; tb_byte = 8'h3C;
        tick(); tick();
        chk("sample_stale_b1", 136'(pin_sample[1]), 136'h00);
        chk("sample_stale_b0", 136'(pin_sample[0]), 136'hA5);
        tick();
        chk("sample_3c", 136'(pin_sample), 136'h3C << 8);
        chk("sample_b16_hi", 136'(pin_sample[16][7:4]), 136'h0);

        // Freeze: drive a different byte1, sample must hold
        tb_oe = 1'b0; write_enable = 1'b1; img[1] = 8'hC3;
        tick();
        chk("freeze_drive_b1", 136'(io_pins[15:8]), 136'hC3);
        tick(); tick(); tick();
        chk("freeze_hold", 136'(pin_sample), 136'h3C << 8);

        write_enable = 1'b0;
        tick();
        chk("unfreeze_release", 136'(io_pins), 136'h0);
        tb_oe = 1'b1; tb_byte = 8'h5A;
        tick(); tick(); tick();
        chk("unfreeze_sample", 136'(pin_sample), 136'h5A << 8);

        // Asynchronous reset in the middle of driving an all-ones image
        tb_oe = 1'b0; write_enable = 1'b1; img = '1;
        tick();
        chk("all_ones_drive", 136'(io_pins), ones);
        #4;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pins", 136'(io_pins), 136'h0);
        chk("async_rst_sample", 136'(pin_sample), 136'h0);
        tick();
        chk("rst_held_pins", 136'(io_pins), 136'h0);

        // Release between edges: nothing moves until the next edge
        img = '0; img[0] = 8'h81;
        #5;
        rst_n = 1'b1;
        #1;
        chk("rst_release_no_edge", 136'(io_pins), 136'h0);
        tick();
        chk("rst_release_drive", 136'(io_pins), 136'h81);
        chk("rst_release_sample", 136'(pin_sample), 136'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
